// File: rtl/stm_delay_framer.sv
// Multi-lane STM serial delay line with selectable tap plus a c4-counted frame strobe, all in clk50.
// Define FRAME_SYNC_EN to realign the frame counter on f0 falls and report off-position syncs.
module stm_delay_framer #(
    parameter  int CHANNELS    = 1,
    parameter  int DEPTH       = 384,
    parameter  int FRAME_LEN   = 25,
    parameter  int PULSE_START = 4,
    parameter  int PULSE_LEN   = 1,
    localparam int TAP_W       = $clog2(DEPTH + 1),
    localparam int CNT_W       = $clog2(FRAME_LEN)
) (
    input  logic                clk50,
    input  logic                reset,
    input  logic                stm_clk,
    input  logic [CHANNELS-1:0] stm_data,
    input  logic [TAP_W-1:0]    tap_sel,
    input  logic                c4,
    input  logic                f0,
    output logic [CHANNELS-1:0] dly_data,
    output logic                primed,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic                frame_pulse,
    output logic                sync_err
);

    localparam logic [TAP_W-1:0] DEPTH_T  = TAP_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    // bit 0 = s1, bit 1 = s2, bit 2 = s3
    logic [2:0]          stm_clk_s;
    logic [2:0]          c4_s;
    logic [CHANNELS-1:0] data_s1;
    logic [CHANNELS-1:0] data_s2;
    logic                stm_rise;
    logic                stm_fall;
    logic                c4_rise;

    logic [DEPTH-1:0]    sr [CHANNELS];
    logic [TAP_W-1:0]    fill_cnt;
    logic [TAP_W-1:0]    eff_tap;
    logic [TAP_W-1:0]    tap_idx;
    logic [CNT_W-1:0]    next_cnt;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            stm_clk_s <= '0;
            c4_s      <= '0;
            data_s1   <= '0;
            data_s2   <= '0;
        end else begin
            stm_clk_s <= {stm_clk_s[1:0], stm_clk};
            c4_s      <= {c4_s[1:0], c4};
            data_s1   <= stm_data;
            data_s2   <= data_s1;
        end
    end

    assign stm_rise = stm_clk_s[1] & ~stm_clk_s[2];
    assign stm_fall = ~stm_clk_s[1] & stm_clk_s[2];
    assign c4_rise  = c4_s[1] & ~c4_s[2];

    always_comb begin
        eff_tap = tap_sel;
        if (tap_sel == '0)
            eff_tap = TAP_W'(1);
        else if (tap_sel > DEPTH_T)
            eff_tap = DEPTH_T;
        tap_idx = eff_tap - 1'b1;
    end

    assign primed = (fill_cnt >= eff_tap);

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            fill_cnt <= '0;
            dly_data <= '0;
            for (int k = 0; k < CHANNELS; k++)
                sr[k] <= '0;
        end else begin
            if (stm_fall) begin
                for (int k = 0; k < CHANNELS; k++)
                    sr[k] <= {sr[k][DEPTH-2:0], data_s2[k]};
                if (fill_cnt != DEPTH_T)
                    fill_cnt <= fill_cnt + 1'b1;
            end
            if (stm_rise) begin
                for (int k = 0; k < CHANNELS; k++)
                    dly_data[k] <= sr[k][tap_idx];
            end
        end
    end

    // Strobe window may wrap past the end of the frame back to count 0.
    function automatic logic in_window(input logic [CNT_W-1:0] cnt);
        int d;
        d = int'(cnt) - PULSE_START;
        if (d < 0)
            d = d + FRAME_LEN;
        return (d < PULSE_LEN);
    endfunction

    assign next_cnt = (frame_cnt == LAST_CNT) ? '0 : frame_cnt + 1'b1;

`ifdef FRAME_SYNC_EN
    logic [2:0] f0_s;
    logic       f0_fall;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset)
            f0_s <= '0;
        else
            f0_s <= {f0_s[1:0], f0};
    end

    assign f0_fall = ~f0_s[1] & f0_s[2];

    // f0 takes priority over a coincident c4 rise; the position check uses the pre-edge count.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            frame_cnt   <= '0;
            frame_pulse <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            sync_err <= f0_fall && (frame_cnt != LAST_CNT);
            if (f0_fall) begin
                frame_cnt   <= '0;
                frame_pulse <= in_window('0);
            end else if (c4_rise) begin
                frame_cnt   <= next_cnt;
                frame_pulse <= in_window(next_cnt);
            end
        end
    end
`else
    logic unused_f0;
    assign unused_f0 = f0;
    assign sync_err  = 1'b0;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            frame_cnt   <= '0;
            frame_pulse <= 1'b0;
        end else if (c4_rise) begin
            frame_cnt   <= next_cnt;
            frame_pulse <= in_window(next_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_stm_delay_framer.sv
// Directed bench for stm_delay_framer: delay line taps/priming and frame strobe/sync behaviour.
module tb_stm_delay_framer;

    localparam int DEPTH     = 384;
    localparam int FRAME_LEN = 25;
    localparam int TAP_W     = 9;
    localparam int CNT_W     = 5;

    logic             clk50 = 1'b0;
    logic             reset;
    logic             stm_clk;
    logic [1:0]       stm_data;
    logic [TAP_W-1:0] tap_sel;
    logic             c4;
    logic             f0;

    logic [1:0]       dly_a, dly_b;
    logic             primed_a, primed_b;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic             pulse_a, pulse_b;
    logic             err_a, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] hist[$];
    int         n_fall;
    int         fc;

    always #10 clk50 = ~clk50;

    stm_delay_framer #(.CHANNELS(2)) u_dut (
        .clk50(clk50), .reset(reset), .stm_clk(stm_clk), .stm_data(stm_data),
        .tap_sel(tap_sel), .c4(c4), .f0(f0), .dly_data(dly_a), .primed(primed_a),
        .frame_cnt(cnt_a), .frame_pulse(pulse_a), .sync_err(err_a)
    );

    stm_delay_framer #(.CHANNELS(2), .PULSE_START(24), .PULSE_LEN(3)) u_dut_wrap (
        .clk50(clk50), .reset(reset), .stm_clk(stm_clk), .stm_data(stm_data),
        .tap_sel(tap_sel), .c4(c4), .f0(f0), .dly_data(dly_b), .primed(primed_b),
        .frame_cnt(cnt_b), .frame_pulse(pulse_b), .sync_err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_tap(input int t);
        if (t == 0) return 1;
        if (t > DEPTH) return DEPTH;
        return t;
    endfunction

    task automatic do_reset();
        @(negedge clk50);
        reset = 1'b1;
        repeat (2) @(negedge clk50);
        reset = 1'b0;
        hist.delete();
        n_fall = 0;
        fc     = 0;
        repeat (4) @(negedge clk50);
    endtask

    // One stm_clk period: fall with new data, then rise; checks the replayed bit and priming.
    task automatic stm_bit(input logic [1:0] d);
        int et;
        logic [1:0] exp_d;
        @(negedge clk50);
        stm_clk  = 1'b0;
        stm_data = d;
        hist.push_back(d);
        n_fall++;
        repeat (4) @(negedge clk50);
        stm_clk = 1'b1;
        repeat (4) @(negedge clk50);
        et    = eff_tap(int'(tap_sel));
        exp_d = (n_fall >= et) ? hist[n_fall - et] : 2'b00;
        check("dly_data", 32'(dly_a), 32'(exp_d));
        check("primed", 32'(primed_a), 32'(((n_fall < DEPTH) ? n_fall : DEPTH) >= et));
    endtask

    task automatic c4_period();
        @(negedge clk50);
        c4 = 1'b1;
        repeat (4) @(negedge clk50);
        c4 = 1'b0;
        repeat (4) @(negedge clk50);
        fc = (fc + 1) % FRAME_LEN;
        check("frame_cnt", 32'(cnt_a), 32'(fc));
        check("pulse_def", 32'(pulse_a), 32'(fc == 4));
        check("pulse_wrap", 32'(pulse_b), 32'(fc == 24 || fc == 0 || fc == 1));
    endtask

    initial begin
        int errs;
        reset    = 1'b1;
        stm_clk  = 1'b1;
        stm_data = 2'b00;
        tap_sel  = 9'd384;
        c4       = 1'b0;
        f0       = 1'b1;
        hist.delete();
        n_fall = 0;
        fc     = 0;
        repeat (3) @(negedge clk50);
        check("rst_dly", 32'(dly_a), 0);
        check("rst_primed", 32'(primed_a), 0);
        check("rst_cnt", 32'(cnt_a), 0);
        check("rst_pulse", 32'(pulse_a), 0);
        check("rst_pulse_wrap", 32'(pulse_b), 0);
        check("rst_sync_err", 32'(err_a), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk50);

        // Full-depth delay with random data on both lanes.
        tap_sel = 9'd384;
        for (int i = 0; i < 400; i++)
            stm_bit(2'($urandom_range(0, 3)));

        // Single one on lane 0 through an 8-deep tap.
        do_reset();
        tap_sel = 9'd8;
        stm_bit(2'b01);
        for (int i = 0; i < 12; i++)
            stm_bit(2'b00);

        // Tap lengthened with fill at 10: priming drops at once, returns after 6 falls.
        do_reset();
        tap_sel = 9'd8;
        for (int i = 0; i < 10; i++)
            stm_bit(2'($urandom_range(0, 3)));
        @(negedge clk50);
        tap_sel = 9'd16;
        @(negedge clk50);
        check("primed_tap_change", 32'(primed_a), 0);
        for (int i = 0; i < 6; i++)
            stm_bit(2'($urandom_range(0, 3)));

        // Out-of-range taps clamp to 1 and DEPTH.
        do_reset();
        tap_sel = 9'd0;
        for (int i = 0; i < 3; i++)
            stm_bit(2'($urandom_range(0, 3)));
        do_reset();
        tap_sel = 9'd500;
        for (int i = 0; i < 3; i++)
            stm_bit(2'b11);

        // Reset mid-operation clears priming immediately.
        do_reset();
        tap_sel = 9'd1;
        stm_bit(2'b11);
        stm_bit(2'b10);
        @(negedge clk50);
        reset = 1'b1;
        #1;
        check("midrst_primed", 32'(primed_a), 0);
        check("midrst_dly", 32'(dly_a), 0);
        do_reset();

        // Frame counter and strobes over 60 c4 periods.
        check("frm_rst_cnt", 32'(cnt_a), 0);
        for (int i = 0; i < 60; i++)
            c4_period();

        // f0 fall together with a c4 rise at count 10.
        errs = 0;
        @(negedge clk50);
        c4 = 1'b1;
        f0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk50);
            if (err_a) errs++;
            if (i == 3) c4 = 1'b0;
        end
`ifdef FRAME_SYNC_EN
        fc = 0;
        check("sync_err_off_pos", 32'(errs), 1);
`else
        fc = 11;
        check("sync_err_tied", 32'(errs), 0);
`endif
        check("sync_cnt", 32'(cnt_a), 32'(fc));
        check("sync_pulse_wrap", 32'(pulse_b), 32'(fc == 24 || fc == 0 || fc == 1));
        f0 = 1'b1;
        repeat (8) @(negedge clk50);

        for (int i = 0; i < 24; i++)
            c4_period();

        // f0 fall alone at the last frame position.
        errs = 0;
        @(negedge clk50);
        f0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk50);
            if (err_a) errs++;
        end
`ifdef FRAME_SYNC_EN
        fc = 0;
`endif
        check("sync_err_on_pos", 32'(errs), 0);
        check("sync_cnt2", 32'(cnt_a), 32'(fc));
        check("sync_pulse_wrap2", 32'(pulse_b), 32'(fc == 24 || fc == 0 || fc == 1));
        f0 = 1'b1;
        repeat (4) @(negedge clk50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
